// File: rtl/uart_tx.sv
// uart_tx: memory-mapped 8N1 serial transmitter with TX FIFO and drain IRQ.
// Define UART_TX_PARITY_EN to add the optional parity bit (PEN/ODD in STATUS).
module uart_tx #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd5208
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:2]  Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    output logic        tx
);

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP
    } state_t;
`endif

    state_t state_q, state_d;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          ie_q, ovf_q;
    logic [15:0]   div_q, div_eff;
    logic [15:0]   per_q, tmr_q;
    logic [7:0]    sh_q;
    logic [2:0]    bit_q;
    logic [1:0]    status_x;
    logic          full, empty, busy;
    logic          push, pop, tick;
    logic          wr_data, wr_ctrl, wr_div;
    logic          unused_din;

    assign wr_data = WE && (Addr == 2'd0);
    assign wr_ctrl = WE && (Addr == 2'd1);
    assign wr_div  = WE && (Addr == 2'd2);

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign busy    = (state_q != S_IDLE);
    assign push    = wr_data && !full;
    assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;
    assign tick    = (tmr_q == per_q - 16'd1);
    assign IRQ     = ie_q && empty && !busy;

    assign unused_din = ^Din[31:16];

`ifdef UART_TX_PARITY_EN
    logic pen_q, odd_q, pen_f, par_q;

    // Frame parity settings are latched at the pop so mid-frame edits wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pen_q <= 1'b0;
            odd_q <= 1'b0;
            pen_f <= 1'b0;
            par_q <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                pen_q <= Din[5];
                odd_q <= Din[6];
            end
            if (pop) begin
                pen_f <= pen_q;
                par_q <= ^mem[rptr_q] ^ odd_q;
            end
        end
    end

    assign status_x = {odd_q, pen_q};
`else
    assign status_x = 2'b00;
`endif

    always_ff @(posedge clk) begin
        if (push) mem[wptr_q] <= Din[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ie_q   <= 1'b0;
            ovf_q  <= 1'b0;
            div_q  <= DIV_RESET;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            if (push && !pop)
                cnt_q <= cnt_q + (AW+1)'(1);
            else if (pop && !push)
                cnt_q <= cnt_q - (AW+1)'(1);
            if (wr_data && full)
                ovf_q <= 1'b1;
            else if (wr_ctrl && Din[4])
                ovf_q <= 1'b0;
            if (wr_ctrl) ie_q  <= Din[3];
            if (wr_div)  div_q <= Din[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: if (tick) state_d = S_DATA;
            S_DATA: begin
                if (tick && bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_d = pen_f ? S_PARITY : S_STOP;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (tick) state_d = S_STOP;
`endif
            S_STOP: if (tick) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The period is reloaded from DIV only at bit boundaries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q <= '0;
            per_q <= 16'd1;
            bit_q <= '0;
            sh_q  <= '0;
        end else if (pop) begin
            tmr_q <= '0;
            per_q <= div_eff;
            bit_q <= '0;
            sh_q  <= mem[rptr_q];
        end else if (busy) begin
            if (tick) begin
                tmr_q <= '0;
                per_q <= div_eff;
                if (state_q == S_DATA) begin
                    sh_q  <= sh_q >> 1;
                    bit_q <= bit_q + 3'd1;
                end
            end else begin
                tmr_q <= tmr_q + 16'd1;
            end
        end
    end

    always_comb begin
        tx = 1'b1;
        unique case (state_q)
            S_START:  tx = 1'b0;
            S_DATA:   tx = sh_q[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx = par_q;
`endif
            default:  tx = 1'b1;
        endcase
    end

    always_comb begin
        Dout = '0;
        unique case (Addr)
            2'd1: Dout = {25'd0, status_x, ovf_q, ie_q,
                          empty, full, busy};
            2'd2: Dout = {16'd0, div_q};
            default: Dout = '0;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized bench for uart_tx, checked against a frame-level
// model of the serial line plus a queue model of the TX FIFO.
module tb_uart_tx;

    localparam int DEPTH = 4;
    localparam int NLOG  = 4096;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:2]  Addr = 2'd0;
    logic        WE = 1'b0;
    logic [31:0] Din = '0;
    logic [31:0] Dout;
    logic        IRQ;
    logic        tx;

    uart_tx #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd5208)) dut (
        .clk(clk), .rst_n(rst_n), .Addr(Addr), .WE(WE),
        .Din(Din), .Dout(Dout), .IRQ(IRQ), .tx(tx)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic txlog  [NLOG];
    logic irqlog [NLOG];
    logic exp_tx [NLOG];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < NLOG) begin
            txlog[cyc]  <= tx;
            irqlog[cyc] <= IRQ;
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d,
                      output int e);
        Addr = a;
        Din  = d;
        WE   = 1'b1;
        @(negedge clk);
        WE = 1'b0;
        e  = cyc;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        Addr = a;
        #1;
        d = Dout;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    function automatic void exp_idle(int a, int b);
        for (int i = a; i <= b; i++)
            if (i >= 0 && i < NLOG) exp_tx[i] = 1'b1;
    endfunction

    function automatic int put_bit(int s, logic v, int d);
        for (int i = 0; i < d; i++)
            if (s + i < NLOG) exp_tx[s + i] = v;
        return s + d;
    endfunction

    function automatic int eff(int d);
        return (d == 0) ? 1 : d;
    endfunction

    // Start bit, 8 data bits LSB first, optional parity, stop bit.
    function automatic int put_frame(int s, logic [7:0] b, int d,
                                     bit pen, bit odd);
        int t;
        t = put_bit(s, 1'b0, d);
        for (int i = 0; i < 8; i++) t = put_bit(t, b[i], d);
        if (pen) t = put_bit(t, (^b) ^ odd, d);
        return put_bit(t, 1'b1, d);
    endfunction

    task automatic test_reset;
        logic [31:0] d;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (tx !== 1'b1 || IRQ !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: tx=%b irq=%b want 1/0", tx, IRQ);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd(2'd1, d);
        checks++;
        if (d !== 32'h4) begin
            errors++;
            $display("FAIL reset_status: got %h want 4", d);
        end
        rd(2'd2, d);
        checks++;
        if (d !== 32'd5208) begin
            errors++;
            $display("FAIL reset_div: got %0d want 5208", d);
        end
        rd(2'd0, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL read_data: got %h want 0", d);
        end
        rd(2'd3, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL read_rsvd: got %h want 0", d);
        end
    endtask

    task automatic test_single_frame;
        int e, k, t, nbusy, fbusy, nbad, first;
        logic [31:0] d;
        wr(2'd2, 32'd4, e);
        wr(2'd0, 32'h55, k);
        exp_idle(k, k + 45);
        t = put_frame(k + 1, 8'h55, 4, 1'b0, 1'b0);
        Addr = 2'd1;
        nbusy = 0;
        fbusy = -1;
        for (int i = 0; i < 42; i++) begin
            #1;
            if (Dout[0] === 1'b1) begin
                nbusy++;
                if (fbusy < 0) fbusy = cyc;
            end
            @(negedge clk);
        end
        checks++;
        if (nbusy !== 40 || fbusy !== k + 1) begin
            errors++;
            $display("FAIL busy_len: got %0d from %0d want 40 from %0d",
                     nbusy, fbusy, k + 1);
        end
        rd(2'd1, d);
        checks++;
        if (d !== 32'h4) begin
            errors++;
            $display("FAIL status_after: got %h want 4", d);
        end
        wait_to(t + 2);
        nbad = 0;
        first = -1;
        for (int i = k; i <= t; i++)
            if (txlog[i] !== exp_tx[i]) begin
                nbad++;
                if (first < 0) first = i;
            end
        checks++;
        if (nbad != 0) begin
            errors++;
            $display("FAIL frame_55: %0d bad, first cyc %0d got %b want %b",
                     nbad, first, txlog[first], exp_tx[first]);
        end
    endtask

    task automatic test_frames;
        int e, k, t, dv, nbad, first;
        logic [7:0] b;
        for (int it = 0; it < 5; it++) begin
            dv = (it == 0) ? 0 : int'($urandom_range(0, 3));
            b  = 8'($urandom);
            wr(2'd2, 32'(dv), e);
            wr(2'd0, {24'd0, b}, k);
            exp_idle(k, k + 10 * eff(dv) + 3);
            t = put_frame(k + 1, b, eff(dv), 1'b0, 1'b0);
            wait_to(t + 3);
            nbad = 0;
            first = -1;
            for (int i = k; i <= t + 1; i++)
                if (txlog[i] !== exp_tx[i]) begin
                    nbad++;
                    if (first < 0) first = i;
                end
            checks++;
            if (nbad != 0) begin
                errors++;
                $display("FAIL frame_rand div=%0d b=%h: %0d bad, cyc %0d got %b want %b",
                         dv, b, nbad, first, txlog[first], exp_tx[first]);
            end
        end
    endtask

    task automatic test_div_change;
        int e, k, t, nbad, first;
        logic [7:0] b;
        b = 8'($urandom);
        wr(2'd2, 32'd3, e);
        wr(2'd0, {24'd0, b}, k);
        wait_to(k + 13);
        wr(2'd2, 32'd8, e);
        exp_idle(k, k + 80);
        t = put_bit(k + 1, 1'b0, 3);
        for (int i = 0; i < 4; i++) t = put_bit(t, b[i], 3);
        for (int i = 4; i < 8; i++) t = put_bit(t, b[i], 8);
        t = put_bit(t, 1'b1, 8);
        wait_to(t + 3);
        nbad = 0;
        first = -1;
        for (int i = k; i <= t + 1; i++)
            if (txlog[i] !== exp_tx[i]) begin
                nbad++;
                if (first < 0) first = i;
            end
        checks++;
        if (nbad != 0) begin
            errors++;
            $display("FAIL div_change b=%h: %0d bad, cyc %0d got %b want %b",
                     b, nbad, first, txlog[first], exp_tx[first]);
        end
    endtask

    task automatic test_fifo_ovf;
        int e, t, wi, pre, idle_at, last, nbad, first;
        int we_t [10];
        logic [7:0] bytes [10];
        bit ovf_at [10];
        bit movf;
        logic [7:0] q [$];
        int fs [$];
        logic [7:0] fb [$];
        logic [7:0] pb;
        logic [31:0] d1, d2;
        for (int i = 0; i < 10; i++) bytes[i] = 8'($urandom);
        wr(2'd2, 32'd2, e);
        Addr = 2'd0;
        WE = 1'b1;
        for (int i = 0; i < 5; i++) begin
            Din = {24'd0, bytes[i]};
            @(negedge clk);
            we_t[i] = cyc;
        end
        WE = 1'b0;
        rd(2'd1, d1);
        Addr = 2'd0;
        WE = 1'b1;
        for (int i = 5; i < 10; i++) begin
            Din = {24'd0, bytes[i]};
            @(negedge clk);
            we_t[i] = cyc;
        end
        WE = 1'b0;
        rd(2'd1, d2);
        // Edge-by-edge queue model: push sees the pre-edge fill level.
        wi = 0;
        movf = 1'b0;
        idle_at = we_t[0];
        for (t = we_t[0]; wi < 10 || q.size() > 0; t++) begin
            pre = q.size();
            if (t >= idle_at && pre > 0) begin
                pb = q.pop_front();
                fs.push_back(t);
                fb.push_back(pb);
                idle_at = t + 21;
            end
            if (wi < 10 && we_t[wi] == t) begin
                if (pre < DEPTH) q.push_back(bytes[wi]);
                else movf = 1'b1;
                ovf_at[wi] = movf;
                wi++;
            end
        end
        checks++;
        if (d1[4] !== ovf_at[4]) begin
            errors++;
            $display("FAIL ovf_first5: got %b want %b", d1[4], ovf_at[4]);
        end
        checks++;
        if (d2[4] !== ovf_at[9]) begin
            errors++;
            $display("FAIL ovf_next5: got %b want %b", d2[4], ovf_at[9]);
        end
        last = fs[fs.size() - 1] + 40;
        exp_idle(we_t[0], last);
        for (int i = 0; i < fs.size(); i++)
            t = put_frame(fs[i], fb[i], 2, 1'b0, 1'b0);
        wait_to(last + 1);
        nbad = 0;
        first = -1;
        for (int i = we_t[0]; i <= last; i++)
            if (txlog[i] !== exp_tx[i]) begin
                nbad++;
                if (first < 0) first = i;
            end
        checks++;
        if (nbad != 0) begin
            errors++;
            $display("FAIL fifo_stream: %0d bad, cyc %0d got %b want %b",
                     nbad, first, txlog[first], exp_tx[first]);
        end
        wr(2'd1, 32'h10, e);
        rd(2'd1, d1);
        checks++;
        if (d1[4] !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b want 0", d1[4]);
        end
    endtask

    task automatic test_irq;
        int e, k, nbad;
        wr(2'd2, 32'd2, e);
        wr(2'd1, 32'h8, e);
        #1;
        checks++;
        if (IRQ !== 1'b1) begin
            errors++;
            $display("FAIL irq_idle: got %b want 1", IRQ);
        end
        wr(2'd0, 32'h0, k);
        #1;
        checks++;
        if (IRQ !== 1'b0) begin
            errors++;
            $display("FAIL irq_push: got %b want 0", IRQ);
        end
        wait_to(k + 23);
        nbad = 0;
        for (int i = k; i <= k + 20; i++)
            if (irqlog[i] !== 1'b0) nbad++;
        checks++;
        if (nbad != 0 || irqlog[k + 21] !== 1'b1) begin
            errors++;
            $display("FAIL irq_frame: %0d high in frame, after stop %b want 1",
                     nbad, irqlog[k + 21]);
        end
        wr(2'd1, 32'h0, e);
        #1;
        checks++;
        if (IRQ !== 1'b0) begin
            errors++;
            $display("FAIL irq_ie_clear: got %b want 0", IRQ);
        end
    endtask

    task automatic test_reset_midframe;
        int e, k, r, nbad;
        logic [7:0] b;
        logic [31:0] d;
        b = 8'($urandom) & 8'hDF;
        wr(2'd1, 32'h8, e);
        wr(2'd2, 32'd4, e);
        wr(2'd0, {24'd0, b}, k);
        wait_to(k + 26);
        #1;
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_bit5: got %b want 0", tx);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || IRQ !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: tx=%b irq=%b want 1/0", tx, IRQ);
        end
        @(negedge clk);
        rst_n = 1'b1;
        r = cyc;
        rd(2'd1, d);
        checks++;
        if (d !== 32'h4) begin
            errors++;
            $display("FAIL rst2_status: got %h want 4", d);
        end
        rd(2'd2, d);
        checks++;
        if (d !== 32'd5208) begin
            errors++;
            $display("FAIL rst2_div: got %0d want 5208", d);
        end
        wait_to(r + 21);
        nbad = 0;
        for (int i = r; i < r + 20; i++)
            if (txlog[i] !== 1'b1) nbad++;
        checks++;
        if (nbad != 0) begin
            errors++;
            $display("FAIL rst2_idle: %0d low samples want 0", nbad);
        end
    endtask

    task automatic test_parity;
        int e, k, t, nbad, first;
        logic [7:0] b;
        logic [31:0] d;
        wr(2'd2, 32'd2, e);
        wr(2'd1, 32'h20, e);
        rd(2'd1, d);
        checks++;
        if (d !== (PAR ? 32'h24 : 32'h04)) begin
            errors++;
            $display("FAIL pen_readback: got %h want %h",
                     d, PAR ? 32'h24 : 32'h04);
        end
        wr(2'd0, 32'h07, k);
        exp_idle(k, k + 30);
        t = put_frame(k + 1, 8'h07, 2, PAR, 1'b0);
        wait_to(t + 3);
        nbad = 0;
        first = -1;
        for (int i = k; i <= t + 1; i++)
            if (txlog[i] !== exp_tx[i]) begin
                nbad++;
                if (first < 0) first = i;
            end
        checks++;
        if (nbad != 0) begin
            errors++;
            $display("FAIL parity_even: %0d bad, cyc %0d got %b want %b",
                     nbad, first, txlog[first], exp_tx[first]);
        end
        wr(2'd1, 32'h60, e);
        rd(2'd1, d);
        checks++;
        if (d !== (PAR ? 32'h64 : 32'h04)) begin
            errors++;
            $display("FAIL odd_readback: got %h want %h",
                     d, PAR ? 32'h64 : 32'h04);
        end
        b = 8'($urandom);
        wr(2'd0, {24'd0, b}, k);
        wait_to(k + 5);
        wr(2'd1, 32'h0, e);
        exp_idle(k, k + 30);
        t = put_frame(k + 1, b, 2, PAR, 1'b1);
        wait_to(t + 3);
        nbad = 0;
        first = -1;
        for (int i = k; i <= t + 1; i++)
            if (txlog[i] !== exp_tx[i]) begin
                nbad++;
                if (first < 0) first = i;
            end
        checks++;
        if (nbad != 0) begin
            errors++;
            $display("FAIL parity_odd b=%h: %0d bad, cyc %0d got %b want %b",
                     b, nbad, first, txlog[first], exp_tx[first]);
        end
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_frames;
        test_div_change;
        test_fifo_ovf;
        test_irq;
        test_reset_midframe;
        test_parity;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Memory-mapped serial transmitter peripheral on a south-bridge device slot; the output-direction counterpart to the button/switch input device.
- CPU stores bytes into a small TX FIFO. An 8N1 serializer (optional parity) shifts them out on a single line at a programmable bit period.
- Raises a level interrupt to the bridge interrupt vector when transmission drains.

Parameters:
- FIFO_DEPTH, 4, TX FIFO entries; power of two, minimum 2.
- DIV_RESET, 16'd5208, bit-period divisor after reset, in clk cycles.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- Addr  input  [3:2]  word select within the device window
- WE  input  1  write strobe, sampled on clk rising edge
- Din  input  32  write data
- Dout  output  32  read data, combinational from Addr
- IRQ  output  1  level interrupt
- tx  output  1  serial line, idle high

Behaviour:
- Register map by Addr:
  - 0 DATA: write pushes Din[7:0] into the FIFO; reads as 0.
  - 1 STATUS/CTRL: bit0 busy, bit1 full, bit2 empty, bit3 IE (R/W), bit4 OVF (sticky; write 1 to clear), bits[31:5] read 0. Only IE and OVF are writable.
  - 2 DIV: bits[15:0] R/W, bits[31:16] read 0.
  - 3 reserved: reads 0, writes ignored.
- Reset (async, rst_n low), all values immediate:
  - tx=1, IRQ=0, FIFO empty, IE=0, OVF=0, DIV=DIV_RESET, FSM=IDLE, bit counter=0.
  - Reset mid-frame aborts the frame immediately; tx returns high.
- FIFO:
  - Push on WE with Addr=0 when not full.
  - Push while full: byte dropped, OVF set.
  - Pop happens only in IDLE, when not empty.
  - A push and a pop in the same cycle are both honoured; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Bit timer:
  - Counts 0..DIV-1; one bit period is DIV cycles.
  - DIV=0 is treated as 1.
  - DIV writes are sampled into the active period at each bit boundary only; the current bit is not stretched.
- FSM:
  - IDLE: if FIFO not empty, pop into the shift register, go to START; tx is high while idle.
  - START: tx=0 for one period, then DATA.
  - DATA: 8 bits LSB first, one period each, then PARITY if enabled, else STOP.
  - PARITY: one period, then STOP.
  - STOP: tx=1 for one period, then IDLE.
  - Back-to-back bytes: the next START begins the cycle after STOP ends (one IDLE cycle).
- Latency: tx falls 2 clk edges after the DATA write edge when idle (push edge, then pop/START edge).
- busy = (FSM != IDLE).
- IRQ = IE & empty & ~busy. Level: it deasserts on the edge that pushes a byte or clears IE.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - STATUS/CTRL bit5 PEN (R/W, reset 0) and bit6 ODD (R/W, reset 0) exist.
  - With PEN=1, a parity bit is sent after data: XOR of the 8 data bits, inverted when ODD=1.
  - PEN and ODD are sampled at the pop in IDLE; changing them mid-frame has no effect on the current frame.
- Undefined: no PARITY state; bits 5 and 6 read 0 and writes to them are ignored; frame is always 10 bits.

Test Plan:
- Reset with DIV=4, write DATA=0x55 -> tx low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, high 4 cycles. busy high for 40 cycles. STATUS reads 0x4 afterward.
- Write 0xA1,0xB2,0xC3,0xD4,0xE5 rapidly, DIV=2, FIFO_DEPTH=4 -> first pop frees a slot, so all five are accepted and OVF=0. Then write 5 more while the line is held busy -> OVF=1 and the dropped byte never appears on tx. Writing STATUS=0x10 clears OVF.
- IE=1, FIFO empty and idle -> IRQ=1. Write DATA=0x00 -> IRQ=0 the next cycle, and IRQ=1 again the cycle after STOP ends.
- DIV=0 -> each bit lasts 1 cycle, frame is 10 cycles. Write DIV=8 during bit 3 -> bit 3 unchanged, bit 4 onward 8 cycles each.
- Assert rst_n low during DATA bit 5 -> tx=1 and IRQ=0 immediately. After release, STATUS=0x4 and DIV=5208.
- UART_TX_PARITY_EN, PEN=1, ODD=0, DATA=0x07 -> parity bit 1, 11-bit frame. ODD=1 -> parity bit 0.
